// File: rtl/vec3_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec3_seq_pkg : shared types and constants for vec3_mul_sequencer            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package vec3_seq_pkg;

   localparam int FLT_W = 32;

   typedef logic [1:0] lane_t;

   localparam lane_t LAST_LANE = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT_Z = 2'd2
   } vec3_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/vec3_mul_sequencer_hs_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hs_watchdog : cycle counter that flags TIMEOUT_CYCLES stalled cycles        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hs_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear || !run) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   // Fires on the edge that would bring the count to TIMEOUT_CYCLES.
   assign expired = run && !clear && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/vec3_mul_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec3_mul_sequencer : time-shares one stb/ack float multiplier over 3 lanes |
// | Optional handshake watchdog: define VEC3_SEQ_TIMEOUT_EN.  Rev 1.0           |
// +----------------------------------------------------------------------------+
module vec3_mul_sequencer
   import vec3_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [FLT_W-1:0] a1,
   input  logic [FLT_W-1:0] a2,
   input  logic [FLT_W-1:0] a3,
   input  logic [FLT_W-1:0] b1,
   input  logic [FLT_W-1:0] b2,
   input  logic [FLT_W-1:0] b3,
   output logic [FLT_W-1:0] mul_a,
   output logic [FLT_W-1:0] mul_b,
   output logic             mul_a_stb,
   output logic             mul_b_stb,
   input  logic             mul_a_ack,
   input  logic             mul_b_ack,
   input  logic [FLT_W-1:0] mul_z,
   input  logic             mul_z_stb,
   output logic             mul_z_ack,
   output logic [FLT_W-1:0] p1,
   output logic [FLT_W-1:0] p2,
   output logic [FLT_W-1:0] p3,
   output logic             out_rdy,
`ifdef VEC3_SEQ_TIMEOUT_EN
   output logic             err,
`endif
   output logic             busy
);

   vec3_seq_state_t  r_state, w_state_nxt;
   lane_t            r_lane, w_lane_nxt;
   logic             r_a_done, r_b_done, w_a_done_nxt, w_b_done_nxt;
   logic             r_out_rdy, w_out_rdy_nxt;
   logic             w_load, w_capture, w_a_xfer, w_b_xfer, w_abort;
   logic [FLT_W-1:0] r_a [3];
   logic [FLT_W-1:0] r_b [3];
   logic [FLT_W-1:0] r_p [3];

   always_comb begin
      w_state_nxt   = r_state;
      w_lane_nxt    = r_lane;
      w_a_done_nxt  = r_a_done;
      w_b_done_nxt  = r_b_done;
      w_out_rdy_nxt = r_out_rdy;
      w_load        = 1'b0;
      w_capture     = 1'b0;
      w_a_xfer      = 1'b0;
      w_b_xfer      = 1'b0;
      mul_a_stb     = 1'b0;
      mul_b_stb     = 1'b0;
      mul_z_ack     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load        = 1'b1;
               w_lane_nxt    = '0;
               w_out_rdy_nxt = 1'b0;
               w_a_done_nxt  = 1'b0;
               w_b_done_nxt  = 1'b0;
               w_state_nxt   = SEND;
            end
         end
         SEND: begin
            // Each strobe retires on its own transfer; the other keeps waiting.
            mul_a_stb    = !r_a_done;
            mul_b_stb    = !r_b_done;
            w_a_xfer     = mul_a_stb && mul_a_ack;
            w_b_xfer     = mul_b_stb && mul_b_ack;
            w_a_done_nxt = r_a_done || w_a_xfer;
            w_b_done_nxt = r_b_done || w_b_xfer;
            if (w_a_done_nxt && w_b_done_nxt) begin
               w_a_done_nxt = 1'b0;
               w_b_done_nxt = 1'b0;
               w_state_nxt  = WAIT_Z;
            end
         end
         WAIT_Z: begin
            mul_z_ack = 1'b1;
            if (mul_z_stb) begin
               w_capture = 1'b1;
               if (r_lane == LAST_LANE) begin
                  w_out_rdy_nxt = 1'b1;
                  w_state_nxt   = IDLE;
               end else begin
                  w_lane_nxt  = r_lane + 2'd1;
                  w_state_nxt = SEND;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         r_lane    <= '0;
         r_a_done  <= 1'b0;
         r_b_done  <= 1'b0;
         r_out_rdy <= 1'b0;
      end else if (w_abort) begin
         r_state   <= IDLE;
         r_a_done  <= 1'b0;
         r_b_done  <= 1'b0;
         r_out_rdy <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lane    <= w_lane_nxt;
         r_a_done  <= w_a_done_nxt;
         r_b_done  <= w_b_done_nxt;
         r_out_rdy <= w_out_rdy_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 3; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
            r_p[i] <= '0;
         end
      end else begin
         if (w_load) begin
            r_a[0] <= a1;
            r_a[1] <= a2;
            r_a[2] <= a3;
            r_b[0] <= b1;
            r_b[1] <= b2;
            r_b[2] <= b3;
         end
         if (w_capture && !w_abort) begin
            r_p[r_lane] <= mul_z;
         end
      end
   end

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (r_lane)
         2'd0: begin
            mul_a = r_a[0];
            mul_b = r_b[0];
         end
         2'd1: begin
            mul_a = r_a[1];
            mul_b = r_b[1];
         end
         2'd2: begin
            mul_a = r_a[2];
            mul_b = r_b[2];
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase
   end

   assign busy    = (r_state != IDLE);
   assign out_rdy = r_out_rdy;
   assign p1      = r_p[0];
   assign p2      = r_p[1];
   assign p3      = r_p[2];

`ifdef VEC3_SEQ_TIMEOUT_EN
   logic w_wd_clear;
   logic r_err;

   // Progress of any kind (state change or operand transfer) restarts the count.
   assign w_wd_clear = (w_state_nxt != r_state) || w_a_xfer || w_b_xfer;

   hs_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_hs_watchdog (
      .clk     (CLK),
      .rst_n   (RST_N),
      .clear   (w_wd_clear),
      .run     (busy),
      .expired (w_abort)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_err <= 1'b0;
      end else if (w_abort) begin
         r_err <= 1'b1;
      end else if (w_load) begin
         r_err <= 1'b0;
      end
   end

   assign err = r_err;
`else
   assign w_abort = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/vec3_mul_sequencer.md
# vec3_mul_sequencer

Drives one shared stb/ack IEEE-754 single-precision multiplier across three component lanes. It latches a pair of 3-vectors and issues operand pairs (a1,b1), (a2,b2), (a3,b3) in order. It acknowledges each product and presents all three products together with `out_rdy`. It is the initiator/consumer end of the multiplier handshake and replaces the three always-strobing multiplier instances in the collision datapath, feeding the add3/sqrt stages from a single multiplier.

## Interface
- `TIMEOUT_CYCLES`, 1024: handshake watchdog limit in cycles; used only with `VEC3_SEQ_TIMEOUT_EN`.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `start` in 1: request; sampled only in IDLE.
- `a1`, `a2`, `a3`, `b1`, `b2`, `b3` in 32 each: float operands; captured on accepted `start`.
- `mul_a`, `mul_b` out 32 each: operands to the multiplier.
- `mul_a_stb`, `mul_b_stb` out 1 each: operand valid strobes.
- `mul_a_ack`, `mul_b_ack` in 1 each: multiplier accepts operand.
- `mul_z` in 32: product.
- `mul_z_stb` in 1: product valid.
- `mul_z_ack` out 1: product accepted.
- `p1`, `p2`, `p3` out 32 each: products a1·b1, a2·b2, a3·b3.
- `out_rdy` out 1: products valid; level signal.
- `busy` out 1: high whenever state ≠ IDLE.
- `err` out 1: watchdog abort; exists only with `VEC3_SEQ_TIMEOUT_EN`.

## Operation
**States and lane counter**
- States: IDLE, SEND, WAIT_Z.
- `lane` is a 2-bit counter taking values 0..2.

**IDLE**
- When `start` is high: latch all six operands, set `lane`=0, clear `out_rdy` (and `err`), go to SEND.

**SEND**
- `mul_a` and `mul_b` carry the operands selected by `lane`.
- Each stb is held high until its own transfer. A transfer is an edge where stb && ack are both high.
- The a and b transfers are independent and may occur on different edges. An acked stb drops and stays low.
- Once both transfers have occurred, go to WAIT_Z.

**WAIT_Z**
- `mul_z_ack` = (state==WAIT_Z), combinational.
- On an edge with `mul_z_stb` high: write `mul_z` into p[lane].
  - If `lane`==2: set `out_rdy`, go to IDLE.
  - Otherwise: increment `lane`, go to SEND.

**Data handling**
- Products are passed through bit-exact; no arithmetic is done in this block.

**Boundary conditions**
- `start` while busy: ignored; there is no queueing.
- `start` in IDLE while `out_rdy`=1: accepted. `out_rdy` falls on that edge; `p1`..`p3` hold their old values until overwritten lane by lane.
- `mul_z_stb` outside WAIT_Z: ignored; `mul_z_ack` stays low.
- `mul_a_ack`/`mul_b_ack` with the matching stb low: ignored.
- `RST_N` low at any time, including mid-transfer: all strobes drop immediately.

## Timing
- Reset values: state IDLE, `lane`=0, all stb/ack outputs 0, `mul_a`/`mul_b`=0, `p1`..`p3`=0, `out_rdy`=0, `busy`=0, `err`=0.
- Edge E0 samples `start`; stbs are high after E0.
- With zero-wait acks, operand transfer happens at E1.
- If the multiplier raises `mul_z_stb` L≥1 edges after the accept, the capture happens at E1+L.
- Per-lane cost is L+1 edges. `out_rdy` is high after edge 3(L+1), counted from E0.
- Each ack wait cycle adds one edge to the corresponding lane.
- `out_rdy` stays high until the next accepted `start` or reset.
- `busy` is high exactly while state ≠ IDLE.

## Configuration
**With `VEC3_SEQ_TIMEOUT_EN` defined**
- A counter clears on every state entry and on every transfer, and increments each cycle in SEND or WAIT_Z.
- When it reaches `TIMEOUT_CYCLES`: drop all stbs/acks, set `err`=1, leave `out_rdy`=0, go to IDLE.
- `err` is cleared by the next accepted `start` or by reset.

**Without the macro**
- No counter and no `err` port.
- The block waits indefinitely on any handshake.

## Structure
- Package `vec3_seq_pkg` contains:
  - state enum `vec3_seq_state_t` (IDLE, SEND, WAIT_Z);
  - `lane_t` (2-bit);
  - `FLT_W`=32;
  - `LAST_LANE`=2.
- One sub-module, `hs_watchdog` (counter plus terminal-count compare), instantiated only under `VEC3_SEQ_TIMEOUT_EN`.
- Lane operand muxing and the FSM stay in the top module.

## Test plan
- **Basic sequence.** a=(1.0,2.0,3.0)=(0x3F800000,0x40000000,0x40400000), b=(2.0,2.0,2.0); model with zero-wait acks and L=2.
  - Required: p1..p3=0x40000000, 0x40800000, 0x40C00000.
  - Required: `out_rdy` high after edge 9 counted from E0.
- **Stalled acks.** Same vectors; `mul_b_ack` delayed 3 cycles on lane 1 while `mul_a_ack` is immediate.
  - Required: `mul_a_stb` drops one edge after its transfer, `mul_b_stb` is held until its transfer, and `out_rdy` arrives 3 edges later than in the basic case.
- **Start while busy.** Pulse `start` with a=(4.0,…) during WAIT_Z of lane 0.
  - Required: ignored; results equal those of the first vectors.
- **Reset mid-operation.** Drop `RST_N` while in WAIT_Z on lane 1.
  - Required: all outputs return to reset values immediately; the next `start` runs cleanly from lane 0.
- **Back-to-back requests.** `start` on the cycle after `out_rdy` rises, with b=(0.5,0.5,0.5).
  - Required: `out_rdy` falls on that edge; new products 0x3F000000, 0x3F800000, 0x3FC00000.
- **Timeout (only with `VEC3_SEQ_TIMEOUT_EN`).** `TIMEOUT_CYCLES`=16 and `mul_z_stb` never asserted.
  - Required: `err`=1 and state IDLE exactly 16 cycles after entering WAIT_Z; `out_rdy`=0.
